// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32-entry register file, one-hot write port D and two combinational read ports A/B
// Optional same-cycle writeback forwarding into the read ports: define WRITE_BYPASS_EN.
module reg_file #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREGS-1:0] Aselect,
  input  logic [NREGS-1:0] Bselect,
  input  logic [NREGS-1:0] Dselect,
  input  logic [WIDTH-1:0] dbus,
  output logic [WIDTH-1:0] abus,
  output logic [WIDTH-1:0] bbus
);

  // r0 is not storage; only r1..r(NREGS-1) exist
  logic [WIDTH-1:0] regs_q [1:NREGS-1];
  logic [WIDTH-1:0] regs_d [1:NREGS-1];
  logic [WIDTH-1:0] rd_src [1:NREGS-1];

  logic unused_sel0;
  assign unused_sel0 = Aselect[0] ^ Bselect[0] ^ Dselect[0];

  always_comb begin
    for (int i = 1; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (Dselect[i]) regs_d[i] = dbus;
    end
  end

  // Writes land on the falling edge so the rising-edge pipeline sees them the same period
  always_ff @(negedge clk) begin
    for (int i = 1; i < NREGS; i++) begin
      if (!rst_n) regs_q[i] <= '0;
      else        regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    for (int i = 1; i < NREGS; i++) begin
      rd_src[i] = regs_q[i];
`ifdef WRITE_BYPASS_EN
      if (rst_n && Dselect[i]) rd_src[i] = dbus;
`else
`endif
    end
  end

  always_comb begin
    abus = '0;
    bbus = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (Aselect[i]) abus = abus | rd_src[i];
      if (Bselect[i]) bbus = bbus | rd_src[i];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - randomized self-checking bench for reg_file against an array model
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [31:0] Aselect;
  logic [31:0] Bselect;
  logic [31:0] Dselect;
  logic [31:0] dbus;
  logic [31:0] abus;
  logic [31:0] bbus;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [0:31];
  bit          model_valid = 0;

`ifdef WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  reg_file #(.WIDTH(32), .NREGS(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Aselect(Aselect),
    .Bselect(Bselect),
    .Dselect(Dselect),
    .dbus   (dbus),
    .abus   (abus),
    .bbus   (bbus)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] sel);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 1; i < 32; i++)
      if (sel[i]) r = r | ((BYPASS && rst_n && Dselect[i]) ? dbus : model[i]);
    return r;
  endfunction

  // One clock period: drive in the high phase, check reads before and after the falling edge
  task automatic cycle(input logic rst, input logic [31:0] dsel, input logic [31:0] d,
                       input logic [31:0] asel, input logic [31:0] bsel, input string tag);
    @(posedge clk);
    #1;
    rst_n = rst; Dselect = dsel; dbus = d; Aselect = asel; Bselect = bsel;
    #1;
    if (model_valid) begin
      check_val({tag, "_pre_a"}, abus, model_read(asel));
      check_val({tag, "_pre_b"}, bbus, model_read(bsel));
    end
    @(negedge clk);
    if (!rst) begin
      for (int i = 1; i < 32; i++) model[i] = 32'h0;
      model_valid = 1;
    end else begin
      for (int i = 1; i < 32; i++) if (dsel[i]) model[i] = d;
    end
    #1;
    if (model_valid) begin
      check_val({tag, "_post_a"}, abus, model_read(asel));
      check_val({tag, "_post_b"}, bbus, model_read(bsel));
    end
  endtask

  function automatic logic [31:0] rand_sel(input logic [31:0] dsel);
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1, 2:    return 32'h1 << $urandom_range(0, 31);
      3:       return $urandom;
      default: return dsel;
    endcase
  endfunction

  logic [31:0] vals [1:31];
  logic [31:0] ds, as, bs;

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst_n = 1'b1; Aselect = '0; Bselect = '0; Dselect = '0; dbus = '0;

    cycle(1'b0, 32'h0, 32'h0, 32'h00000002, 32'h80000000, "reset");
    check_val("reset_abus", abus, 32'h0);
    check_val("reset_bbus", bbus, 32'h0);

    cycle(1'b1, 32'h02000000, 32'h76543210, 32'h02000000, 32'h00000001, "basic");
    check_val("basic_abus", abus, 32'h76543210);
    check_val("basic_bbus", bbus, 32'h0);

    cycle(1'b1, 32'h00000001, 32'h00001111, 32'h00000001, 32'h02000000, "zero");
    check_val("zero_abus", abus, 32'h0);
    check_val("zero_bbus", bbus, 32'h76543210);

    cycle(1'b1, 32'h00040000, 32'h10101010, 32'h00040000, 32'h00040000, "same");
    check_val("same_abus", abus, 32'h10101010);
    check_val("same_bbus", bbus, 32'h10101010);

    for (int i = 1; i < 32; i++) vals[i] = $urandom ^ (32'(i) << 24);
    vals[31] = 32'h33333333;
    vals[11] = 32'h000062DE;
    for (int i = 1; i < 32; i++)
      cycle(1'b1, 32'h1 << i, vals[i], 32'h1 << i, 32'h1 << (32 - i), "fill");
    for (int i = 1; i < 32; i++) begin
      cycle(1'b1, 32'h0, 32'h0, 32'h1 << i, 32'h1 << (32 - i), "persist");
      check_val("persist_a", abus, vals[i]);
      check_val("persist_b", bbus, (i == 1) ? vals[31] : vals[32 - i]);
    end

    cycle(1'b1, 32'h00001000, 32'hF4820000, 32'h00001000, 32'h0, "r12");
    check_val("r12_abus", abus, 32'hF4820000);
    cycle(1'b0, 32'h00001000, 32'hFFFFFFFF, 32'h00001000, 32'h80000000, "midrst");
    check_val("midrst_abus", abus, 32'h0);
    check_val("midrst_bbus", bbus, 32'h0);
    cycle(1'b1, 32'h0, 32'h0, 32'h0, 32'h00001000, "zsel");
    check_val("zsel_abus", abus, 32'h0);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0:       ds = 32'h0;
        1:       ds = $urandom;
        default: ds = 32'h1 << $urandom_range(0, 31);
      endcase
      as = rand_sel(ds);
      bs = rand_sel(ds);
      cycle(($urandom_range(0, 24) != 0), ds, $urandom, as, bs, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", total, 0);
    $fatal(1);
  end

endmodule
